// File: rtl/npc_sequencer_pkg.sv
// Shared definitions for the SPARC PC/nPC sequencer.
// This package holds the FSM state encoding and the default reset and increment constants.
package npc_sequencer_pkg;

    typedef enum logic [1:0] {
        SEQ_BOOT  = 2'd0,
        SEQ_RUN   = 2'd1,
        SEQ_ANNUL = 2'd2,
        SEQ_TRAP  = 2'd3
    } seq_state_e;

    localparam logic [31:0] SEQ_INSTR_BYTES  = 32'd4;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/npc_sequencer.sv
// SPARC PC/nPC sequencer: drives the external PC register with pc_next/pc_ld and owns nPC.
// It implements delayed branches, the annul bit, trap redirection and stall; all outputs are registered.
module npc_sequencer
    import npc_sequencer_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = RESET_PC_DEFAULT,
    parameter logic [31:0] INSTR_BYTES = SEQ_INSTR_BYTES
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        stall,
    input  logic        br_valid,
    input  logic        br_taken,
    input  logic        br_always,
    input  logic        br_annul,
    input  logic [31:0] br_target,
    input  logic        trap_req,
    input  logic [31:0] trap_vector,
    output logic [31:0] pc_next,
    output logic        pc_ld,
    output logic [31:0] npc_out,
    output logic        annul_slot,
    output logic [1:0]  seq_state
);

    seq_state_e  state_q, state_d;
    logic [31:0] pc_next_q, pc_next_d;
    logic [31:0] npc_q, npc_d;
    logic        pc_ld_q, pc_ld_d;
    logic        annul_q, annul_d;

    logic advance;
    logic take_trap;
    logic br_allowed;
    logic take_branch;
    logic squash_next;

    // A stall freezes every state except BOOT.
    assign advance     = (state_q != SEQ_BOOT) && !stall;
    assign take_trap   = advance && trap_req && (state_q inside {SEQ_RUN, SEQ_ANNUL});
    // The squashed slot in ANNUL cannot branch, so branch inputs only count in RUN.
    assign br_allowed  = advance && !take_trap && (state_q == SEQ_RUN) && br_valid;
    assign take_branch = br_allowed && br_taken;
    assign squash_next = br_allowed && (br_taken ? (br_always && br_annul) : br_annul);

    // NOTE: the reset branch sits inside the clocked block, so reset is synchronous as required.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= SEQ_BOOT;
            pc_next_q <= RESET_PC;
            npc_q     <= RESET_PC + INSTR_BYTES;
            pc_ld_q   <= 1'b0;
            annul_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_next_q <= pc_next_d;
            npc_q     <= npc_d;
            pc_ld_q   <= pc_ld_d;
            annul_q   <= annul_d;
        end
    end

    // NOTE: each combinational block assigns a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            SEQ_BOOT: state_d = SEQ_RUN;
            SEQ_RUN, SEQ_ANNUL: begin
                if (take_trap)        state_d = SEQ_TRAP;
                else if (squash_next) state_d = SEQ_ANNUL;
                else if (advance)     state_d = SEQ_RUN;
            end
            SEQ_TRAP: if (advance) state_d = SEQ_RUN;
            default:  state_d = SEQ_BOOT;
        endcase
    end

    always_comb begin
        pc_next_d = pc_next_q;
        npc_d     = npc_q;
        pc_ld_d   = 1'b0;
        annul_d   = annul_q;
        if (state_q == SEQ_BOOT) begin
            pc_next_d = RESET_PC;
            pc_ld_d   = 1'b1;
            annul_d   = 1'b0;
        end else if (take_trap) begin
            pc_next_d = trap_vector;
            npc_d     = trap_vector + INSTR_BYTES;
            pc_ld_d   = 1'b1;
            annul_d   = 1'b1;
        end else if (advance) begin
            // The delay slot (the old nPC) always enters PC; only the new nPC depends on the branch.
            pc_next_d = npc_q;
            npc_d     = take_branch ? br_target : npc_q + INSTR_BYTES;
            pc_ld_d   = 1'b1;
            annul_d   = squash_next;
        end
    end

    assign pc_next    = pc_next_q;
    assign pc_ld      = pc_ld_q;
    assign npc_out    = npc_q;
    assign annul_slot = annul_q;
    assign seq_state  = state_q;

endmodule

// File: tb/tb_npc_sequencer.sv
// Self-checking bench for npc_sequencer: directed delayed-branch scenarios plus a randomized run
// compared against a behavioural PC/nPC model that tracks pending boot, flush and squash conditions.
module tb_npc_sequencer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        stall;
    logic        br_valid;
    logic        br_taken;
    logic        br_always;
    logic        br_annul;
    logic [31:0] br_target;
    logic        trap_req;
    logic [31:0] trap_vector;
    logic [31:0] pc_next;
    logic        pc_ld;
    logic [31:0] npc_out;
    logic        annul_slot;
    logic [1:0]  seq_state;

    int n_checks = 0;
    int n_fail   = 0;

    typedef logic [67:0] vec_t;

    npc_sequencer dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .stall       (stall),
        .br_valid    (br_valid),
        .br_taken    (br_taken),
        .br_always   (br_always),
        .br_annul    (br_annul),
        .br_target   (br_target),
        .trap_req    (trap_req),
        .trap_vector (trap_vector),
        .pc_next     (pc_next),
        .pc_ld       (pc_ld),
        .npc_out     (npc_out),
        .annul_slot  (annul_slot),
        .seq_state   (seq_state)
    );

    always #5 clk = ~clk;

    // Reference model: PC/nPC pair plus three pending conditions.
    logic [31:0] m_pc, m_npc;
    logic        m_ld, m_annul;
    bit          m_boot, m_flush;

    function automatic vec_t pack(input logic [31:0] pc, input logic [31:0] npc,
                                  input logic ld, input logic an, input logic [1:0] st);
        return {pc, npc, ld, an, st};
    endfunction

    function automatic vec_t observed();
        return {pc_next, npc_out, pc_ld, annul_slot, seq_state};
    endfunction

    function automatic vec_t modelled();
        logic [1:0] st;
        if (m_boot)       st = 2'd0;
        else if (m_flush) st = 2'd3;
        else if (m_annul) st = 2'd2;
        else              st = 2'd1;
        return {m_pc, m_npc, m_ld, m_annul, st};
    endfunction

    task automatic model_step();
        logic [31:0] new_npc;
        logic        squash;
        if (!reset_n) begin
            m_pc = 32'h0; m_npc = 32'h4; m_ld = 1'b0; m_annul = 1'b0;
            m_boot = 1'b1; m_flush = 1'b0;
        end else if (m_boot) begin
            m_pc = 32'h0; m_ld = 1'b1; m_boot = 1'b0;
        end else if (stall) begin
            m_ld = 1'b0;
        end else if (m_flush) begin
            m_pc = m_npc; m_npc = m_npc + 32'd4; m_ld = 1'b1; m_annul = 1'b0; m_flush = 1'b0;
        end else if (trap_req) begin
            m_pc = trap_vector; m_npc = trap_vector + 32'd4; m_ld = 1'b1;
            m_annul = 1'b1; m_flush = 1'b1;
        end else begin
            new_npc = m_npc + 32'd4;
            squash  = 1'b0;
            // A squashed instruction (annul_slot high) cannot itself branch.
            if (!m_annul && br_valid) begin
                if (br_taken) begin
                    new_npc = br_target;
                    squash  = br_always & br_annul;
                end else begin
                    squash  = br_annul;
                end
            end
            m_pc = m_npc; m_npc = new_npc; m_ld = 1'b1; m_annul = squash;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic idle_inputs();
        stall = 1'b0; br_valid = 1'b0; br_taken = 1'b0; br_always = 1'b0;
        br_annul = 1'b0; br_target = 32'h0; trap_req = 1'b0; trap_vector = 32'h0;
    endtask

    // Reset, boot, then two sequential steps: PC=8, nPC=C.
    task automatic go_to_npc_c();
        idle_inputs();
        reset_n = 1'b0; tick();
        reset_n = 1'b1; tick(); tick(); tick();
    endtask

    task automatic test_reset();
        vec_t exp;
        idle_inputs();
        br_valid = 1'b1; br_taken = 1'b1; trap_req = 1'b1; trap_vector = 32'h300; stall = 1'b1;
        reset_n = 1'b0;
        tick();
        exp = pack(32'h0, 32'h4, 1'b0, 1'b0, 2'd0);
        n_checks++;
        if (observed() !== exp) begin
            n_fail++;
            $display("FAIL reset_state: got %h expected %h", observed(), exp);
        end
        idle_inputs();
    endtask

    task automatic test_boot_sequential();
        vec_t exp;
        logic [31:0] pcs [4]  = '{32'h4, 32'h8, 32'hC, 32'h10};
        logic [31:0] npcs [4] = '{32'h8, 32'hC, 32'h10, 32'h14};
        reset_n = 1'b1;
        tick();
        exp = pack(32'h0, 32'h4, 1'b1, 1'b0, 2'd1);
        n_checks++;
        if (observed() !== exp) begin
            n_fail++;
            $display("FAIL boot_cycle: got %h expected %h", observed(), exp);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            exp = pack(pcs[i], npcs[i], 1'b1, 1'b0, 2'd1);
            n_checks++;
            if (observed() !== exp) begin
                n_fail++;
                $display("FAIL sequential_%0d: got %h expected %h", i, observed(), exp);
            end
        end
    endtask

    task automatic test_branch_taken();
        vec_t exp [3];
        go_to_npc_c();
        br_valid = 1'b1; br_taken = 1'b1; br_annul = 1'b0; br_target = 32'h40;
        exp[0] = pack(32'hC,  32'h40, 1'b1, 1'b0, 2'd1);
        exp[1] = pack(32'h40, 32'h44, 1'b1, 1'b0, 2'd1);
        exp[2] = pack(32'h44, 32'h48, 1'b1, 1'b0, 2'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            idle_inputs();
            n_checks++;
            if (observed() !== exp[i]) begin
                n_fail++;
                $display("FAIL branch_taken_%0d: got %h expected %h", i, observed(), exp[i]);
            end
        end
    endtask

    task automatic test_annul_not_taken();
        vec_t exp;
        go_to_npc_c();
        br_valid = 1'b1; br_taken = 1'b0; br_annul = 1'b1; br_target = 32'h40;
        tick();
        exp = pack(32'hC, 32'h10, 1'b1, 1'b1, 2'd2);
        n_checks++;
        if (observed() !== exp) begin
            n_fail++;
            $display("FAIL annul_untaken_slot: got %h expected %h", observed(), exp);
        end
        // A taken branch presented during the squashed slot must be ignored.
        br_taken = 1'b1; br_annul = 1'b0; br_target = 32'h99C;
        tick();
        idle_inputs();
        exp = pack(32'h10, 32'h14, 1'b1, 1'b0, 2'd1);
        n_checks++;
        if (observed() !== exp) begin
            n_fail++;
            $display("FAIL annul_ignores_branch: got %h expected %h", observed(), exp);
        end
    endtask

    task automatic test_ba_annul();
        vec_t exp [3];
        go_to_npc_c();
        br_valid = 1'b1; br_taken = 1'b1; br_always = 1'b1; br_annul = 1'b1; br_target = 32'h80;
        exp[0] = pack(32'hC,  32'h80, 1'b1, 1'b1, 2'd2);
        exp[1] = pack(32'h80, 32'h84, 1'b1, 1'b0, 2'd1);
        exp[2] = pack(32'h84, 32'h88, 1'b1, 1'b0, 2'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            idle_inputs();
            n_checks++;
            if (observed() !== exp[i]) begin
                n_fail++;
                $display("FAIL ba_annul_%0d: got %h expected %h", i, observed(), exp[i]);
            end
        end
    endtask

    task automatic test_trap_priority();
        vec_t exp [3];
        go_to_npc_c();
        br_valid = 1'b1; br_taken = 1'b1; br_target = 32'h40;
        trap_req = 1'b1; trap_vector = 32'h200;
        exp[0] = pack(32'h200, 32'h204, 1'b1, 1'b1, 2'd3);
        exp[1] = pack(32'h204, 32'h208, 1'b1, 1'b0, 2'd1);
        exp[2] = pack(32'h208, 32'h20C, 1'b1, 1'b0, 2'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            // trap_req stays high into the TRAP cycle, where it must be ignored.
            if (i == 1) idle_inputs();
            n_checks++;
            if (observed() !== exp[i]) begin
                n_fail++;
                $display("FAIL trap_priority_%0d: got %h expected %h", i, observed(), exp[i]);
            end
        end
    endtask

    task automatic test_stall();
        vec_t exp;
        go_to_npc_c();
        tick(); tick(); tick();
        stall = 1'b1; trap_req = 1'b1; trap_vector = 32'h300;
        br_valid = 1'b1; br_taken = 1'b1; br_target = 32'h500;
        for (int i = 0; i < 3; i++) begin
            tick();
            exp = pack(32'h14, 32'h18, 1'b0, 1'b0, 2'd1);
            n_checks++;
            if (observed() !== exp) begin
                n_fail++;
                $display("FAIL stall_hold_%0d: got %h expected %h", i, observed(), exp);
            end
        end
        idle_inputs();
        tick();
        exp = pack(32'h18, 32'h1C, 1'b1, 1'b0, 2'd1);
        n_checks++;
        if (observed() !== exp) begin
            n_fail++;
            $display("FAIL stall_resume: got %h expected %h", observed(), exp);
        end
    endtask

    task automatic test_reset_in_trap();
        vec_t exp;
        trap_req = 1'b1; trap_vector = 32'h200;
        tick();
        idle_inputs();
        n_checks++;
        if (seq_state !== 2'd3) begin
            n_fail++;
            $display("FAIL trap_entry_state: got %0d expected 3", seq_state);
        end
        reset_n = 1'b0;
        tick();
        exp = pack(32'h0, 32'h4, 1'b0, 1'b0, 2'd0);
        n_checks++;
        if (observed() !== exp) begin
            n_fail++;
            $display("FAIL reset_during_trap: got %h expected %h", observed(), exp);
        end
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_wrap();
        vec_t exp [3];
        trap_req = 1'b1; trap_vector = 32'hFFFF_FFF8;
        exp[0] = pack(32'hFFFF_FFF8, 32'hFFFF_FFFC, 1'b1, 1'b1, 2'd3);
        exp[1] = pack(32'hFFFF_FFFC, 32'h0000_0000, 1'b1, 1'b0, 2'd1);
        exp[2] = pack(32'h0000_0000, 32'h0000_0004, 1'b1, 1'b0, 2'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            idle_inputs();
            n_checks++;
            if (observed() !== exp[i]) begin
                n_fail++;
                $display("FAIL wrap_%0d: got %h expected %h", i, observed(), exp[i]);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            reset_n     = ($urandom_range(0, 99) >= 2);
            stall       = ($urandom_range(0, 99) < 20);
            br_valid    = ($urandom_range(0, 99) < 35);
            br_taken    = $urandom_range(0, 1) == 1;
            br_always   = $urandom_range(0, 1) == 1;
            br_annul    = $urandom_range(0, 1) == 1;
            br_target   = $urandom() & 32'hFFFF_FFFC;
            trap_req    = ($urandom_range(0, 99) < 8);
            trap_vector = ($urandom_range(0, 99) < 10) ? 32'hFFFF_FFF8 : ($urandom() & 32'hFFFF_FFFC);
            tick();
            n_checks++;
            if (observed() !== modelled()) begin
                n_fail++;
                $display("FAIL random_cycle_%0d: got %h expected %h", i, observed(), modelled());
            end
        end
        idle_inputs();
        reset_n = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        idle_inputs();
        reset_n = 1'b0;
        m_pc = '0; m_npc = '0; m_ld = 1'b0; m_annul = 1'b0; m_boot = 1'b1; m_flush = 1'b0;
        test_reset();
        test_boot_sequential();
        test_branch_taken();
        test_annul_not_taken();
        test_ba_annul();
        test_trap_priority();
        test_stall();
        test_reset_in_trap();
        test_wrap();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
